csr_exec_unit: RTL and testbench
================================

# csr_exec_unit

CSR instruction execution unit sitting directly upstream of the user-level CSR file. It accepts decoded Zicsr instructions (CSRRW/CSRRS/CSRRC and their immediate forms) from the execute stage and performs legality checks. It then runs the read-modify-write sequence against the CSR file port (`csr_addr`/`csr_rdata`/`csr_we`/`csr_wdata`) and returns the old CSR value for register writeback through a valid/ready response channel.

## Interface
- `XLEN`, 64, data width of CSRs and GPR values.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_funct3`  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- `req_csr`  in  12  CSR address.
- `req_rs1_val`  in  XLEN  rs1 register value.
- `req_rs1_idx`  in  5  rs1 index; doubles as uimm for immediate forms.
- `req_rd`  in  5  destination register index.
- `req_priv`  in  2  current privilege (0 U, 1 S, 3 M).
- `csr_addr`  out  12  address to CSR file.
- `csr_rdata`  in  XLEN  combinational read data from CSR file.
- `csr_we`  out  1  CSR write strobe, one cycle.
- `csr_wdata`  out  XLEN  CSR write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rd`  out  5  destination register.
- `rsp_rd_we`  out  1  write rsp_data into rsp_rd.
- `rsp_data`  out  XLEN  old CSR value.
- `rsp_illegal`  out  1  illegal-instruction exception flag.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch all req fields and go to READ.
- READ: drive `csr_addr` = latched address and capture `csr_rdata` as old value. Compute src, new value and legality. Go to WRITE if the access is legal and needs a write, else go to RESP.
- WRITE: `csr_we`=1 and `csr_wdata`=new value for exactly one cycle, then go to RESP.
- RESP: `rsp_valid`=1 and all rsp_* outputs stable. On `rsp_ready`, go to IDLE.
- src: for funct3[2]=0, src = `req_rs1_val`. For funct3[2]=1, src = zero-extended 5-bit `req_rs1_idx`.
- new value: RW/RWI give src. RS/RSI give old | src. RC/RCI give old & ~src.
- Write needed: RW/RWI always. RS/RC/RSI/RCI only when `req_rs1_idx` != 0.
- Illegal conditions (any one suffices):
  - funct3 is 000 or 100;
  - write needed and `req_csr[11:10]`==2'b11 (read-only space);
  - `req_priv` < `req_csr[9:8]`.
- Illegal response: no CSR write, `rsp_illegal`=1, `rsp_rd_we`=0, `rsp_data`=0.
- Legal response: `rsp_illegal`=0, `rsp_data`=old value, `rsp_rd_we` = (rd != 0).
- Reads of unmapped addresses return whatever the CSR file returns (0). No extra check is made here.
- `csr_addr` holds the latched address in READ/WRITE/RESP and is 0 in IDLE. `csr_wdata` is 0 outside WRITE.

## Timing
- Reset values: state IDLE. `req_ready`=0 while reset is asserted, 1 in the first cycle after. `csr_we`, `rsp_valid`, `rsp_rd_we`, `rsp_illegal` are 0. `csr_addr`, `csr_wdata`, `rsp_data` are 0. `rsp_rd` is 0.
- Accept edge at cycle 0. READ occupies cycle 1 and WRITE cycle 2. `rsp_valid` rises in cycle 3 for writing ops and in cycle 2 for non-writing or illegal ops.
- Throughput: one instruction per transaction. `req_ready`=0 from READ until the cycle after the RESP handshake.
- `req_ready` is combinational from state only, never from `req_valid`. `rsp_valid` does not depend on `rsp_ready`.
- Backpressure: RESP holds indefinitely and all outputs stay stable. The next request is accepted no earlier than the cycle after the handshake.
- Reset mid-operation: the next edge returns to IDLE and discards the latched op. `csr_we` is gated by !reset, so no write issues during a reset cycle. `rsp_valid` is 0 after reset.
- Write happens at most once per instruction. The old value is the value sampled in READ, before the write.

## Test plan
- CSRRW rd=5, csr=0x040, rs1_val=0xDEADBEEF, priv=0, CSR initially 0. Expect: `csr_we` in cycle 2 with wdata 0xDEADBEEF; `rsp_valid` cycle 3; rsp_data=0, rd_we=1, rsp_rd=5.
- CSR 0x040=0x0F, CSRRS rs1_idx=3, rs1_val=0xF0, rd=0. Expect: wdata 0xFF; rsp_data=0x0F; rd_we=0.
- CSR 0x042=0x3C, CSRRCI uimm=0, rd=7. Expect: no `csr_we`; `rsp_valid` cycle 2; rsp_data=0x3C, rd_we=1. Repeat with uimm=0x0C: wdata 0x30.
- Illegal cases, each giving no `csr_we`, rsp_illegal=1, rd_we=0, rsp_data=0:
  - CSRRW csr=0xC00 (read-only space);
  - CSRRS csr=0x300 with priv=0 (privilege);
  - funct3=100.
- Same case, CSRRS csr=0xC00 rs1_idx=0: legal read, rsp_illegal=0.
- Hold `rsp_ready` low for 3 cycles in RESP. Expect: rsp_* stable, `req_ready`=0, CSR written exactly once. A back-to-back `req_valid` is accepted in the cycle after the handshake.
- Assert reset during WRITE state. Expect: `csr_we`=0 that cycle, state IDLE next cycle, `rsp_valid`=0, `req_ready`=1 after reset deasserts.

Source files
------------

// File: rtl/csr_exec_if.sv
// Bus bundle for the CSR execution unit: request channel, CSR file port and response channel.
// The master side is the execute stage plus CSR file; the slave side is csr_exec_unit.
interface csr_exec_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_csr;
  logic [XLEN-1:0] req_rs1_val;
  logic [4:0]      req_rs1_idx;
  logic [4:0]      req_rd;
  logic [1:0]      req_priv;

  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_rd;
  logic            rsp_rd_we;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr, req_rs1_val, req_rs1_idx, req_rd, req_priv,
    input  req_ready,
    input  csr_addr, csr_we, csr_wdata,
    output csr_rdata,
    input  rsp_valid, rsp_rd, rsp_rd_we, rsp_data, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_csr, req_rs1_val, req_rs1_idx, req_rd, req_priv,
    output req_ready,
    output csr_addr, csr_we, csr_wdata,
    input  csr_rdata,
    output rsp_valid, rsp_rd, rsp_rd_we, rsp_data, rsp_illegal,
    input  rsp_ready
  );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr execution unit: legality checks and a single read-modify-write against the CSR file,
// returning the pre-write CSR value through a valid/ready response channel.
module csr_exec_unit #(
  parameter int XLEN = 64
) (
  input  logic         clk,
  input  logic         reset,
  csr_exec_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      funct3_reg;
  logic [11:0]     csr_reg;
  logic [XLEN-1:0] rs1_val_reg;
  logic [4:0]      rs1_idx_reg;
  logic [4:0]      rd_reg;
  logic [1:0]      priv_reg;
  logic [XLEN-1:0] old_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            illegal_reg;
  logic            rd_we_reg;

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_value;
  logic            op_known;
  logic            write_needed;
  logic            illegal;
  logic            accept;

  // Operation decode works on the latched request; only meaningful while in READ.
  always_comb begin
    src          = funct3_reg[2] ? {{(XLEN-5){1'b0}}, rs1_idx_reg} : rs1_val_reg;
    op_known     = (funct3_reg[1:0] != 2'b00);
    write_needed = (funct3_reg[1:0] == 2'b01) || (rs1_idx_reg != 5'd0);
    unique case (funct3_reg[1:0])
      2'b10:   new_value = bus.csr_rdata | src;
      2'b11:   new_value = bus.csr_rdata & ~src;
      default: new_value = src;
    endcase
    illegal = !op_known
           || (write_needed && (csr_reg[11:10] == 2'b11))
           || (priv_reg < csr_reg[9:8]);
  end

  assign accept = (state_reg == IDLE) && bus.req_valid;

  always_comb begin
    state_next      = state_reg;
    bus.req_ready   = 1'b0;
    bus.csr_addr    = 12'd0;
    bus.csr_we      = 1'b0;
    bus.csr_wdata   = '0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rd      = 5'd0;
    bus.rsp_rd_we   = 1'b0;
    bus.rsp_data    = '0;
    bus.rsp_illegal = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bus.req_ready = !reset;
        if (accept) state_next = READ;
      end
      READ: begin
        bus.csr_addr = csr_reg;
        state_next   = (!illegal && write_needed) ? WRITE : RESP;
      end
      WRITE: begin
        bus.csr_addr  = csr_reg;
        // A reset arriving in this cycle must not let the write escape.
        bus.csr_we    = !reset;
        bus.csr_wdata = wdata_reg;
        state_next    = RESP;
      end
      RESP: begin
        bus.csr_addr    = csr_reg;
        bus.rsp_valid   = !reset;
        bus.rsp_rd      = rd_reg;
        bus.rsp_rd_we   = rd_we_reg;
        bus.rsp_data    = old_reg;
        bus.rsp_illegal = illegal_reg;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      funct3_reg  <= 3'd0;
      csr_reg     <= 12'd0;
      rs1_val_reg <= '0;
      rs1_idx_reg <= 5'd0;
      rd_reg      <= 5'd0;
      priv_reg    <= 2'd0;
      old_reg     <= '0;
      wdata_reg   <= '0;
      illegal_reg <= 1'b0;
      rd_we_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        funct3_reg  <= bus.req_funct3;
        csr_reg     <= bus.req_csr;
        rs1_val_reg <= bus.req_rs1_val;
        rs1_idx_reg <= bus.req_rs1_idx;
        rd_reg      <= bus.req_rd;
        priv_reg    <= bus.req_priv;
      end
      if (state_reg == READ) begin
        // Old value is captured before any write; illegal ops report zero data.
        old_reg     <= illegal ? '0 : bus.csr_rdata;
        wdata_reg   <= new_value;
        illegal_reg <= illegal;
        rd_we_reg   <= !illegal && (rd_reg != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed testbench for csr_exec_unit with a behavioural CSR file attached to its port.
module tb_csr_exec_unit;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csr_exec_if #(.XLEN(XLEN)) bus();
  csr_exec_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [XLEN-1:0] csr_mem [0:4095];
  logic            bd_we = 1'b0;
  logic [11:0]     bd_addr = 12'd0;
  logic [XLEN-1:0] bd_data = '0;
  int              wr_count = 0;

  assign bus.csr_rdata = csr_mem[bus.csr_addr];

  always @(posedge clk) begin
    if (bus.csr_we) begin
      csr_mem[bus.csr_addr] <= bus.csr_wdata;
      wr_count <= wr_count + 1;
    end else if (bd_we) begin
      csr_mem[bd_addr] <= bd_data;
    end
  end

  int errors = 0;
  int checks = 0;
  int got_we_n, got_we_cycle, got_rsp_cycle;
  logic [XLEN-1:0] got_wdata, got_data;
  logic [4:0] got_rd;
  logic got_rd_we, got_ill;

  task automatic preload(input logic [11:0] addr, input logic [XLEN-1:0] data);
    bd_addr = addr; bd_data = data; bd_we = 1'b1;
    @(posedge clk); @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [XLEN-1:0] val,
                       input logic [4:0] idx, input logic [4:0] rd, input logic [1:0] priv);
    int n = 0;
    bus.req_funct3 = f3; bus.req_csr = csr; bus.req_rs1_val = val;
    bus.req_rs1_idx = idx; bus.req_rd = rd; bus.req_priv = priv; bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 10) begin @(posedge clk); @(negedge clk); n++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_timeout: req_ready=%b expected 1", bus.req_ready);
    end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Called at the negedge of cycle 1 (READ); returns at the first negedge with rsp_valid.
  task automatic collect();
    int c = 1;
    bit done = 1'b0;
    got_we_n = 0; got_we_cycle = 0; got_rsp_cycle = 0; got_wdata = '0;
    while (!done && c < 20) begin
      if (bus.csr_we) begin got_we_n++; got_we_cycle = c; got_wdata = bus.csr_wdata; end
      if (bus.rsp_valid) begin
        done = 1'b1; got_rsp_cycle = c; got_data = bus.rsp_data;
        got_rd = bus.rsp_rd; got_rd_we = bus.rsp_rd_we; got_ill = bus.rsp_illegal;
      end else begin
        @(posedge clk); @(negedge clk); c++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles expected 1", bus.rsp_valid, c); end
    $display("txn csr=%h f3=%b writes=%0d we_cycle=%0d wdata=%h rsp_cycle=%0d data=%h rd=%0d rd_we=%b illegal=%b",
             bus.req_csr, bus.req_funct3, got_we_n, got_we_cycle, got_wdata, got_rsp_cycle,
             got_data, got_rd, got_rd_we, got_ill);
  endtask

  task automatic finish_op();
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] csr, input logic [XLEN-1:0] val,
                        input logic [4:0] idx, input logic [4:0] rd, input logic [1:0] priv);
    issue(f3, csr, val, idx, rd, priv);
    collect();
    finish_op();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL reset_csr_we: got %b expected 0", bus.csr_we); end
    checks++; if (bus.csr_addr !== 12'd0) begin errors++; $display("FAIL reset_csr_addr: got %h expected 0", bus.csr_addr); end
    checks++; if (bus.rsp_data !== 64'd0 || bus.rsp_rd !== 5'd0 || bus.csr_wdata !== 64'd0)
      begin errors++; $display("FAIL reset_data: rsp_data=%h rsp_rd=%0d wdata=%h expected all 0", bus.rsp_data, bus.rsp_rd, bus.csr_wdata); end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_rw();
    preload(12'h040, 64'h0);
    run_op(3'b001, 12'h040, 64'hDEADBEEF, 5'd1, 5'd5, 2'd0);
    checks++; if (got_we_n != 1 || got_we_cycle != 2) begin errors++; $display("FAIL rw_we: writes=%0d cycle=%0d expected 1 at 2", got_we_n, got_we_cycle); end
    checks++; if (got_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL rw_wdata: got %h expected deadbeef", got_wdata); end
    checks++; if (got_rsp_cycle != 3) begin errors++; $display("FAIL rw_rsp_cycle: got %0d expected 3", got_rsp_cycle); end
    checks++; if (got_data !== 64'h0 || got_rd_we !== 1'b1 || got_rd !== 5'd5 || got_ill !== 1'b0)
      begin errors++; $display("FAIL rw_rsp: data=%h rd_we=%b rd=%0d ill=%b expected 0/1/5/0", got_data, got_rd_we, got_rd, got_ill); end
    checks++; if (csr_mem[12'h040] !== 64'hDEADBEEF) begin errors++; $display("FAIL rw_csr: got %h expected deadbeef", csr_mem[12'h040]); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rw_idle: req_ready=%b expected 1", bus.req_ready); end
  endtask

  task automatic test_set_clear();
    run_op(3'b001, 12'h040, 64'h0F, 5'd2, 5'd0, 2'd0);
    checks++; if (got_data !== 64'hDEADBEEF || got_rd_we !== 1'b0) begin errors++; $display("FAIL rw_rd0: data=%h rd_we=%b expected deadbeef/0", got_data, got_rd_we); end
    run_op(3'b010, 12'h040, 64'hF0, 5'd3, 5'd0, 2'd0);
    checks++; if (got_wdata !== 64'hFF || got_we_cycle != 2) begin errors++; $display("FAIL rs_wdata: got %h at %0d expected ff at 2", got_wdata, got_we_cycle); end
    checks++; if (got_data !== 64'h0F || got_rd_we !== 1'b0) begin errors++; $display("FAIL rs_rsp: data=%h rd_we=%b expected 0f/0", got_data, got_rd_we); end
    preload(12'h042, 64'h3C);
    run_op(3'b111, 12'h042, 64'hFFFF, 5'd0, 5'd7, 2'd0);
    checks++; if (got_we_n != 0) begin errors++; $display("FAIL rci0_we: writes=%0d expected 0", got_we_n); end
    checks++; if (got_rsp_cycle != 2) begin errors++; $display("FAIL rci0_rsp_cycle: got %0d expected 2", got_rsp_cycle); end
    checks++; if (got_data !== 64'h3C || got_rd_we !== 1'b1 || got_rd !== 5'd7) begin errors++; $display("FAIL rci0_rsp: data=%h rd_we=%b rd=%0d expected 3c/1/7", got_data, got_rd_we, got_rd); end
    run_op(3'b111, 12'h042, 64'hFFFF, 5'h0C, 5'd7, 2'd0);
    checks++; if (got_wdata !== 64'h30 || got_we_n != 1) begin errors++; $display("FAIL rci_wdata: got %h writes=%0d expected 30/1", got_wdata, got_we_n); end
    checks++; if (got_data !== 64'h3C) begin errors++; $display("FAIL rci_data: got %h expected 3c", got_data); end
    run_op(3'b110, 12'h042, 64'hFFFF, 5'h03, 5'd1, 2'd0);
    checks++; if (got_wdata !== 64'h33 || got_data !== 64'h30) begin errors++; $display("FAIL rsi: wdata=%h data=%h expected 33/30", got_wdata, got_data); end
    run_op(3'b011, 12'h042, 64'h0F, 5'd4, 5'd1, 2'd0);
    checks++; if (got_wdata !== 64'h30 || got_data !== 64'h33) begin errors++; $display("FAIL rc: wdata=%h data=%h expected 30/33", got_wdata, got_data); end
    run_op(3'b101, 12'h042, 64'hFFFF, 5'd0, 5'd1, 2'd0);
    checks++; if (got_we_n != 1 || got_wdata !== 64'h0 || got_data !== 64'h30) begin errors++; $display("FAIL rwi0: writes=%0d wdata=%h data=%h expected 1/0/30", got_we_n, got_wdata, got_data); end
  endtask

  task automatic test_illegal();
    preload(12'hC00, 64'h1234);
    preload(12'h300, 64'h55);
    run_op(3'b001, 12'hC00, 64'hAA, 5'd1, 5'd3, 2'd3);
    checks++; if (got_we_n != 0 || got_ill !== 1'b1 || got_rd_we !== 1'b0 || got_data !== 64'h0 || got_rsp_cycle != 2)
      begin errors++; $display("FAIL ill_ro: writes=%0d ill=%b rd_we=%b data=%h cyc=%0d expected 0/1/0/0/2", got_we_n, got_ill, got_rd_we, got_data, got_rsp_cycle); end
    checks++; if (csr_mem[12'hC00] !== 64'h1234) begin errors++; $display("FAIL ill_ro_csr: got %h expected 1234", csr_mem[12'hC00]); end
    run_op(3'b010, 12'h300, 64'h1, 5'd1, 5'd3, 2'd0);
    checks++; if (got_we_n != 0 || got_ill !== 1'b1 || got_rd_we !== 1'b0 || got_data !== 64'h0)
      begin errors++; $display("FAIL ill_priv: writes=%0d ill=%b rd_we=%b data=%h expected 0/1/0/0", got_we_n, got_ill, got_rd_we, got_data); end
    run_op(3'b100, 12'h040, 64'h1, 5'd1, 5'd3, 2'd3);
    checks++; if (got_we_n != 0 || got_ill !== 1'b1 || got_rd_we !== 1'b0 || got_data !== 64'h0)
      begin errors++; $display("FAIL ill_f3_100: writes=%0d ill=%b rd_we=%b data=%h expected 0/1/0/0", got_we_n, got_ill, got_rd_we, got_data); end
    run_op(3'b000, 12'h040, 64'h1, 5'd1, 5'd3, 2'd3);
    checks++; if (got_we_n != 0 || got_ill !== 1'b1) begin errors++; $display("FAIL ill_f3_000: writes=%0d ill=%b expected 0/1", got_we_n, got_ill); end
    run_op(3'b010, 12'hC00, 64'h1, 5'd0, 5'd2, 2'd0);
    checks++; if (got_we_n != 0 || got_ill !== 1'b0 || got_data !== 64'h1234 || got_rd_we !== 1'b1)
      begin errors++; $display("FAIL ro_read: writes=%0d ill=%b data=%h rd_we=%b expected 0/0/1234/1", got_we_n, got_ill, got_data, got_rd_we); end
    run_op(3'b010, 12'h300, 64'h1, 5'd0, 5'd2, 2'd3);
    checks++; if (got_ill !== 1'b0 || got_data !== 64'h55) begin errors++; $display("FAIL mpriv_read: ill=%b data=%h expected 0/55", got_ill, got_data); end
  endtask

  task automatic test_back_to_back();
    int w0;
    preload(12'h041, 64'h77);
    bus.rsp_ready = 1'b0;
    issue(3'b001, 12'h041, 64'hA5A5, 5'd1, 5'd9, 2'd3);
    collect();
    checks++; if (got_data !== 64'h77 || got_wdata !== 64'hA5A5) begin errors++; $display("FAIL bp_rsp: data=%h wdata=%h expected 77/a5a5", got_data, got_wdata); end
    w0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h77 || bus.rsp_rd !== 5'd9 || bus.rsp_rd_we !== 1'b1 || bus.req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: valid=%b data=%h rd=%0d rd_we=%b req_ready=%b expected 1/77/9/1/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_rd, bus.rsp_rd_we, bus.req_ready); end
    end
    checks++; if (wr_count != w0 || csr_mem[12'h041] !== 64'hA5A5) begin errors++; $display("FAIL bp_once: extra writes=%0d csr=%h expected 0/a5a5", wr_count - w0, csr_mem[12'h041]); end
    bus.req_funct3 = 3'b010; bus.req_csr = 12'h041; bus.req_rs1_val = 64'h0;
    bus.req_rs1_idx = 5'd0; bus.req_rd = 5'd10; bus.req_priv = 2'd3;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_handshake_ready: got %b expected 0", bus.req_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: rsp_valid=%b req_ready=%b expected 0/1", bus.rsp_valid, bus.req_ready); end
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.csr_addr !== 12'h041 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: csr_addr=%h req_ready=%b expected 041/0", bus.csr_addr, bus.req_ready); end
    collect();
    finish_op();
    checks++; if (got_data !== 64'hA5A5 || got_rsp_cycle != 2 || got_rd !== 5'd10 || wr_count != w0)
      begin errors++; $display("FAIL b2b_rsp: data=%h cyc=%0d rd=%0d extra writes=%0d expected a5a5/2/10/0", got_data, got_rsp_cycle, got_rd, wr_count - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    preload(12'h043, 64'h11);
    w0 = wr_count;
    issue(3'b001, 12'h043, 64'h99, 5'd1, 5'd4, 2'd3);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.csr_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b expected 0", bus.csr_we); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.csr_addr !== 12'd0)
      begin errors++; $display("FAIL rstmid_state: rsp_valid=%b req_ready=%b csr_addr=%h expected 0/0/0", bus.rsp_valid, bus.req_ready, bus.csr_addr); end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: req_ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid); end
    checks++; if (wr_count != w0 || csr_mem[12'h043] !== 64'h11) begin errors++; $display("FAIL rstmid_nowrite: writes=%0d csr=%h expected 0/11", wr_count - w0, csr_mem[12'h043]); end
    run_op(3'b010, 12'h043, 64'h0, 5'd0, 5'd4, 2'd3);
    checks++; if (got_data !== 64'h11 || got_ill !== 1'b0) begin errors++; $display("FAIL rstmid_recover: data=%h ill=%b expected 11/0", got_data, got_ill); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_csr = 12'd0; bus.req_rs1_val = '0;
    bus.req_rs1_idx = 5'd0; bus.req_rd = 5'd0; bus.req_priv = 2'd0; bus.rsp_ready = 1'b1;
    test_reset();
    test_rw();
    test_set_clear();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t expected finished", $time);
    $fatal(1, "timeout");
  end
endmodule
